// File: rtl/hdr_frame_reader.sv
// HDR frame reader: fetches 256-bit bursts into a ping-pong buffer and streams RGB565 pixels.
// Define UNDERRUN_CNT_EN to add the saturating underrun_count output.
module hdr_frame_reader #(
    parameter logic [24:0] START_ADDR = 25'hE1000,
    parameter logic [24:0] END_ADDR   = 25'h12BFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         ram_busy,
    output logic         rd_req,
    output logic [24:0]  rd_address,
    input  logic         rd_valid,
    input  logic [255:0] rd_data,
    input  logic         pixel_rd,
    output logic [15:0]  pixel_data,
    output logic         pixel_valid,
    output logic         frame_start,
`ifdef UNDERRUN_CNT_EN
    output logic [15:0]  underrun_count,
`endif
    output logic         underrun
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [24:0]  addr_q, addr_d;
    logic [1:0]   full_q, full_d;
    logic [1:0]   start_q, start_d;
    logic         wr_sel_q, wr_sel_d;
    logic         act_q, act_d;
    logic [3:0]   idx_q, idx_d;
    logic [15:0]  pix_q, pix_d;
    logic         valid_q, valid_d;
    logic         fs_q, fs_d;
    logic         under_q, under_d;
    logic         buf_we;
    logic [15:0]  word;
    logic [255:0] buf_q [2];

    // Fills and drains both proceed in buffer order 0,1,0,1..., so the fill pointer always
    // names the next empty buffer and the active buffer is always the oldest full one.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        full_d   = full_q;
        start_d  = start_q;
        wr_sel_d = wr_sel_q;
        act_d    = act_q;
        idx_d    = idx_q;
        pix_d    = pix_q;
        valid_d  = 1'b0;
        fs_d     = 1'b0;
        under_d  = 1'b0;
        buf_we   = 1'b0;
        word     = buf_q[act_q][{idx_q, 4'b0000} +: 16];

        case (state_q)
            StIdle: begin
                if (enable && !full_q[wr_sel_q]) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (!ram_busy) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (rd_valid) begin
                    buf_we           = 1'b1;
                    full_d[wr_sel_q] = 1'b1;
                    start_d[wr_sel_q] = (addr_q == START_ADDR);
                    wr_sel_d         = ~wr_sel_q;
                    addr_d           = (addr_q < END_ADDR) ? addr_q + 25'd4 : START_ADDR;
                    state_d          = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (pixel_rd) begin
            if (full_q[act_q]) begin
                pix_d   = {word[7:0], word[15:8]};
                valid_d = 1'b1;
                fs_d    = start_q[act_q] && (idx_q == 4'd0);
                idx_d   = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    full_d[act_q] = 1'b0;
                    act_d         = ~act_q;
                end
            end else begin
                under_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= START_ADDR;
            full_q   <= 2'b00;
            start_q  <= 2'b00;
            wr_sel_q <= 1'b0;
            act_q    <= 1'b0;
            idx_q    <= 4'd0;
            pix_q    <= 16'd0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            full_q   <= full_d;
            start_q  <= start_d;
            wr_sel_q <= wr_sel_d;
            act_q    <= act_d;
            idx_q    <= idx_d;
            pix_q    <= pix_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
            under_q  <= under_d;
        end
    end

    // Burst storage needs no reset; the full flags gate every read.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[wr_sel_q] <= rd_data;
        end
    end

`ifdef UNDERRUN_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else if (fs_d) begin
            cnt_q <= 16'd0;
        end else if (under_d && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign underrun_count = cnt_q;
`endif

    assign rd_req      = (state_q == StReq) && !ram_busy;
    assign rd_address  = addr_q;
    assign pixel_data  = pix_q;
    assign pixel_valid = valid_q;
    assign frame_start = fs_q;
    assign underrun    = under_q;

endmodule

// File: tb/tb_hdr_frame_reader.sv
// Bench for hdr_frame_reader: directed scenarios plus a randomized run against a pixel-queue
// model. A second instance with a start address near the wrap point covers address wrap.
`timescale 1ns/1ps
module tb_hdr_frame_reader;
    localparam logic [24:0] M_START = 25'hE1000;
    localparam logic [24:0] W_START = 25'h12BFF0;
    localparam logic [24:0] END_A   = 25'h12BFFF;

    logic         clk = 1'b0;
    logic         rst, enable, ram_busy, rd_valid, pixel_rd;
    logic [255:0] rd_data;
    logic         rd_req, pixel_valid, frame_start, underrun;
    logic [24:0]  rd_address;
    logic [15:0]  pixel_data;
    logic         w_rd_req, w_pixel_valid, w_frame_start, w_underrun;
    logic [24:0]  w_rd_address;
    logic [15:0]  w_pixel_data;
`ifdef UNDERRUN_CNT_EN
    logic [15:0]  underrun_count, w_underrun_count;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hdr_frame_reader u_dut (
        .clk(clk), .rst(rst), .enable(enable), .ram_busy(ram_busy),
        .rd_req(rd_req), .rd_address(rd_address), .rd_valid(rd_valid), .rd_data(rd_data),
        .pixel_rd(pixel_rd), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .frame_start(frame_start),
`ifdef UNDERRUN_CNT_EN
        .underrun_count(underrun_count),
`endif
        .underrun(underrun)
    );

    hdr_frame_reader #(.START_ADDR(W_START), .END_ADDR(END_A)) u_wrap (
        .clk(clk), .rst(rst), .enable(enable), .ram_busy(ram_busy),
        .rd_req(w_rd_req), .rd_address(w_rd_address), .rd_valid(rd_valid), .rd_data(rd_data),
        .pixel_rd(pixel_rd), .pixel_data(w_pixel_data), .pixel_valid(w_pixel_valid),
        .frame_start(w_frame_start),
`ifdef UNDERRUN_CNT_EN
        .underrun_count(w_underrun_count),
`endif
        .underrun(w_underrun)
    );

    function automatic logic [15:0] pix_of(input logic [255:0] d, input int k);
        logic [15:0] w;
        w = d[k*16 +: 16];
        return {w[7:0], w[15:8]};
    endfunction

    function automatic logic [24:0] next_addr(input logic [24:0] a, input logic [24:0] s);
        return (a < END_A) ? a + 25'd4 : s;
    endfunction

    function automatic logic [255:0] rand_burst();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; ram_busy = 1'b0; rd_valid = 1'b0; pixel_rd = 1'b0;
        rd_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a request; returns with the accepting edge already passed.
    task automatic wait_req(input int max, output bit ok, output logic [24:0] a,
                            output logic [24:0] wa);
        ok = 1'b0; a = '0; wa = '0;
        for (int i = 0; i < max && !ok; i++) begin
            #1;
            if (rd_req === 1'b1) begin
                ok = 1'b1; a = rd_address; wa = w_rd_address;
            end
            tick();
        end
    endtask

    task automatic respond(input logic [255:0] d);
        rd_valid = 1'b1;
        rd_data  = d;
        tick();
        rd_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            n_tests++; if (rd_req !== 1'b0) begin n_fail++;
                $display("FAIL reset_rd_req: got %b want 0", rd_req); end
            n_tests++; if (rd_address !== M_START) begin n_fail++;
                $display("FAIL reset_rd_address: got %h want %h", rd_address, M_START); end
            n_tests++; if (w_rd_address !== W_START) begin n_fail++;
                $display("FAIL reset_w_rd_address: got %h want %h", w_rd_address, W_START); end
            n_tests++; if (pixel_valid !== 1'b0 || frame_start !== 1'b0 || underrun !== 1'b0)
                begin n_fail++; $display("FAIL reset_flags: got %b%b%b want 000",
                pixel_valid, frame_start, underrun); end
            n_tests++; if (pixel_data !== 16'h0000) begin n_fail++;
                $display("FAIL reset_pixel_data: got %h want 0000", pixel_data); end
`ifdef UNDERRUN_CNT_EN
            n_tests++; if (underrun_count !== 16'd0) begin n_fail++;
                $display("FAIL reset_count: got %0d want 0", underrun_count); end
`endif
            tick();
        end
    endtask

    task automatic test_fetch_and_pixels();
        bit ok;
        logic [24:0] a, wa;
        logic [255:0] d0, d1;
        logic [15:0] exp;
        do_reset();
        enable = 1'b1;
        wait_req(10, ok, a, wa);
        n_tests++; if (!ok || a !== M_START || wa !== W_START) begin n_fail++;
            $display("FAIL first_req: ok=%b got %h/%h want %h/%h", ok, a, wa, M_START, W_START);
        end
        d0 = rand_burst();
        d0[15:0] = 16'hA5F8;
        respond(d0);
        wait_req(10, ok, a, wa);
        n_tests++; if (!ok || a !== 25'hE1004 || wa !== 25'h12BFF4) begin n_fail++;
            $display("FAIL second_req: ok=%b got %h/%h want 0e1004/12bff4", ok, a, wa); end
        d1 = rand_burst();
        respond(d1);
        enable = 1'b0;
        exp = 16'h0;
        pixel_rd = 1'b1;
        for (int k = 0; k < 32; k++) begin
            tick();
            exp = (k < 16) ? pix_of(d0, k) : pix_of(d1, k - 16);
            if (k == 0) begin
                n_tests++; if (pixel_data !== 16'hF8A5) begin n_fail++;
                    $display("FAIL first_pixel: got %h want f8a5", pixel_data); end
            end
            n_tests++; if (pixel_valid !== 1'b1 || pixel_data !== exp) begin n_fail++;
                $display("FAIL pixel_%0d: got v=%b %h want v=1 %h", k, pixel_valid,
                pixel_data, exp); end
            n_tests++; if (frame_start !== (k == 0) || w_frame_start !== (k == 0)) begin
                n_fail++; $display("FAIL frame_start_%0d: got %b/%b want %b", k, frame_start,
                w_frame_start, k == 0); end
        end
        tick();
        n_tests++; if (underrun !== 1'b1 || pixel_valid !== 1'b0) begin n_fail++;
            $display("FAIL underrun_empty: got u=%b v=%b want u=1 v=0", underrun, pixel_valid);
        end
        n_tests++; if (pixel_data !== exp) begin n_fail++;
            $display("FAIL underrun_hold: got %h want %h", pixel_data, exp); end
`ifdef UNDERRUN_CNT_EN
        n_tests++; if (underrun_count !== 16'd1) begin n_fail++;
            $display("FAIL underrun_count: got %0d want 1", underrun_count); end
`endif
        pixel_rd = 1'b0;
        tick();
        n_tests++; if (underrun !== 1'b0) begin n_fail++;
            $display("FAIL underrun_pulse: got %b want 0", underrun); end
    endtask

    task automatic test_busy();
        bit ok;
        logic [24:0] a, wa;
        do_reset();
        enable = 1'b1;
        ram_busy = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++; if (rd_req !== 1'b0) begin n_fail++;
                $display("FAIL busy_hold_%0d: got %b want 0", c, rd_req); end
            tick();
        end
        ram_busy = 1'b0;
        #1;
        n_tests++; if (rd_req !== 1'b1 || rd_address !== M_START) begin n_fail++;
            $display("FAIL busy_release: got %b %h want 1 %h", rd_req, rd_address, M_START);
        end
        tick();
        #1;
        n_tests++; if (rd_req !== 1'b0) begin n_fail++;
            $display("FAIL busy_single_pulse: got %b want 0", rd_req); end
        respond(rand_burst());
        enable = 1'b0;
        wait_req(3, ok, a, wa);
    endtask

    task automatic test_wrap();
        bit ok;
        logic [24:0] a, wa;
        logic [24:0] wseq [6];
        wseq = '{25'h12BFF0, 25'h12BFF4, 25'h12BFF8, 25'h12BFFC, 25'h12C000, 25'h12BFF0};
        do_reset();
        enable = 1'b1;
        for (int b = 0; b < 6; b++) begin
            wait_req(10, ok, a, wa);
            n_tests++; if (!ok || wa !== wseq[b] || a !== M_START + 25'(4 * b)) begin
                n_fail++; $display("FAIL wrap_addr_%0d: ok=%b got %h/%h want %h/%h", b, ok,
                wa, a, wseq[b], M_START + 25'(4 * b)); end
            respond(rand_burst());
            ram_busy = 1'b1;
            pixel_rd = 1'b1;
            for (int k = 0; k < 16; k++) tick();
            pixel_rd = 1'b0;
            ram_busy = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [24:0] a, wa;
        logic [255:0] d;
        do_reset();
        enable = 1'b1;
        wait_req(10, ok, a, wa);
        rst = 1'b1;
        ram_busy = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rd_valid = 1'b1;
        rd_data  = rand_burst();
        tick();
        rd_valid = 1'b0;
        pixel_rd = 1'b1;
        tick();
        n_tests++; if (underrun !== 1'b1 || pixel_valid !== 1'b0 || pixel_data !== 16'h0)
            begin n_fail++; $display("FAIL late_valid_ignored: got u=%b v=%b %h want 1 0 0000",
            underrun, pixel_valid, pixel_data); end
        pixel_rd = 1'b0;
        ram_busy = 1'b0;
        wait_req(10, ok, a, wa);
        n_tests++; if (!ok || a !== M_START || wa !== W_START) begin n_fail++;
            $display("FAIL reset_mid_req: ok=%b got %h/%h want %h/%h", ok, a, wa, M_START,
            W_START); end
        d = rand_burst();
        respond(d);
        enable = 1'b0;
        pixel_rd = 1'b1;
        tick();
        pixel_rd = 1'b0;
        n_tests++; if (pixel_valid !== 1'b1 || pixel_data !== pix_of(d, 0) ||
            frame_start !== 1'b1) begin n_fail++;
            $display("FAIL reset_mid_pixel: got v=%b %h fs=%b want 1 %h 1", pixel_valid,
            pixel_data, frame_start, pix_of(d, 0)); end
    endtask

    task automatic test_random();
        logic [17:0] q[$];
        logic [17:0] e;
        bit outstanding;
        logic [24:0] m_exp, w_exp, m_req, w_req;
        logic exp_valid, exp_fs, exp_wfs, exp_under;
        logic [15:0] exp_pix;
        int m_cnt, w_cnt, streak, cap;
        q.delete();
        outstanding = 1'b0;
        m_exp = M_START; w_exp = W_START; m_req = '0; w_req = '0;
        exp_valid = 1'b0; exp_fs = 1'b0; exp_wfs = 1'b0; exp_under = 1'b0; exp_pix = '0;
        m_cnt = 0; w_cnt = 0; streak = 0;
        do_reset();
        enable = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            n_tests++; if (pixel_valid !== exp_valid || w_pixel_valid !== exp_valid) begin
                n_fail++; $display("FAIL rnd_valid@%0d: got %b/%b want %b", cyc, pixel_valid,
                w_pixel_valid, exp_valid); end
            n_tests++; if (pixel_data !== exp_pix || w_pixel_data !== exp_pix) begin
                n_fail++; $display("FAIL rnd_data@%0d: got %h/%h want %h", cyc, pixel_data,
                w_pixel_data, exp_pix); end
            n_tests++; if (frame_start !== exp_fs || w_frame_start !== exp_wfs) begin
                n_fail++; $display("FAIL rnd_frame@%0d: got %b/%b want %b/%b", cyc,
                frame_start, w_frame_start, exp_fs, exp_wfs); end
            n_tests++; if (underrun !== exp_under || w_underrun !== exp_under) begin
                n_fail++; $display("FAIL rnd_underrun@%0d: got %b/%b want %b", cyc, underrun,
                w_underrun, exp_under); end
`ifdef UNDERRUN_CNT_EN
            n_tests++; if (underrun_count !== 16'(m_cnt) || w_underrun_count !== 16'(w_cnt))
                begin n_fail++; $display("FAIL rnd_count@%0d: got %0d/%0d want %0d/%0d", cyc,
                underrun_count, w_underrun_count, m_cnt, w_cnt); end
`endif
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            ram_busy = ($urandom_range(0, 3) == 0);
            pixel_rd = ($urandom_range(0, 1) == 0);
            rd_valid = outstanding ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            rd_data  = rand_burst();
            #1;
            cap = (q.size() + 15) / 16;
            n_tests++; if (w_rd_req !== rd_req) begin n_fail++;
                $display("FAIL rnd_req_match@%0d: got %b/%b", cyc, rd_req, w_rd_req); end
            if (rd_req === 1'b1) begin
                n_tests++; if (rd_address !== m_exp || w_rd_address !== w_exp) begin n_fail++;
                    $display("FAIL rnd_addr@%0d: got %h/%h want %h/%h", cyc, rd_address,
                    w_rd_address, m_exp, w_exp); end
                n_tests++; if (outstanding || cap >= 2) begin n_fail++;
                    $display("FAIL rnd_req_allowed@%0d: got outstanding=%b bufs=%0d want 0 <2",
                    cyc, outstanding, cap); end
            end
            if (enable && !outstanding && cap < 2 && rd_req !== 1'b1) streak++;
            else streak = 0;
            n_tests++; if (streak > 40) begin n_fail++;
                $display("FAIL rnd_no_request@%0d: got idle %0d cycles want <=40", cyc, streak);
                streak = 0; end
            exp_fs = 1'b0; exp_wfs = 1'b0; exp_under = 1'b0; exp_valid = 1'b0;
            if (pixel_rd) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    exp_valid = 1'b1; exp_pix = e[15:0]; exp_fs = e[16]; exp_wfs = e[17];
                    if (e[16]) m_cnt = 0;
                    if (e[17]) w_cnt = 0;
                end else begin
                    exp_under = 1'b1;
                    if (m_cnt < 65535) m_cnt++;
                    if (w_cnt < 65535) w_cnt++;
                end
            end
            if (rd_valid && outstanding) begin
                for (int k = 0; k < 16; k++)
                    q.push_back({(w_req == W_START) && k == 0, (m_req == M_START) && k == 0,
                                 pix_of(rd_data, k)});
                outstanding = 1'b0;
                m_exp = next_addr(m_exp, M_START);
                w_exp = next_addr(w_exp, W_START);
            end
            if (rd_req === 1'b1) begin
                outstanding = 1'b1; m_req = rd_address; w_req = w_rd_address;
            end
            @(posedge clk);
            #1;
        end
        pixel_rd = 1'b0; rd_valid = 1'b0; enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_and_pixels();
        test_busy();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
